async_mem: RTL and testbench



---
 rtl/async_mem.sv | 76 +++++++
 tb/tb_async_mem.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/async_mem.sv
// Single-port RAM: clocked write, combinational read, all-ones idle value.
// Define ASYNC_MEM_CLEAR_EN to build the reset clear sequencer that fills every word with INIT.
module async_mem #(
  parameter int asz = 7,
  parameter int depth = 127,
  parameter int dsz = 8,
  parameter logic [dsz-1:0] INIT = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [asz-1:0] addr,
  input  logic [dsz-1:0] wr_data,
  input  logic           wr_cs,
  input  logic           rd_cs,
  output logic [dsz-1:0] rd_data,
  output logic           busy
);

  logic [dsz-1:0] mem [depth];
  logic           addr_ok;
  logic           user_we;

  // Wide compare so depth == 2**asz is handled without overflow.
  assign addr_ok = ({1'b0, addr} < (asz+1)'(depth));

`ifdef ASYNC_MEM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t         state, state_nxt;
  logic [asz-1:0] cnt, cnt_nxt;
  logic           clr_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    if (state == CLEAR && !reset) begin
      clr_we  = 1'b1;
      cnt_nxt = cnt + 1'b1;
      if (cnt == asz'(depth - 1)) state_nxt = IDLE;
    end
  end

  // Reset is OR-ed in so busy is high from the moment reset is applied.
  assign busy    = reset || (state == CLEAR);
  assign user_we = wr_cs && addr_ok && !busy;

  always_ff @(posedge clock) begin
    if (clr_we) mem[cnt] <= INIT;
    else if (user_we) mem[addr] <= wr_data;
  end
`else
  logic unused_reset;
  assign unused_reset = reset;

  assign busy    = 1'b0;
  assign user_we = wr_cs && addr_ok;

  always_ff @(posedge clock) begin
    if (user_we) mem[addr] <= wr_data;
  end
`endif

  assign rd_data = (rd_cs && addr_ok && !busy) ? mem[addr] : '1;

endmodule

// File: tb/tb_async_mem.sv
// Directed bench for async_mem: clear sequencing, write/read table, chip-select gating.
// Clear-sequencer checks are built when ASYNC_MEM_CLEAR_EN is defined.
module tb_async_mem;
  localparam int asz = 7;
  localparam int depth = 127;
  localparam int dsz = 8;

  logic           clock;
  logic           reset;
  logic [asz-1:0] addr;
  logic [dsz-1:0] wr_data;
  logic           wr_cs;
  logic           rd_cs;
  logic [dsz-1:0] rd_data;
  logic           busy;

  int n_checks = 0;
  int n_fail = 0;
  logic [dsz-1:0] exp_q[$];

  async_mem #(.asz(asz), .depth(depth), .dsz(dsz), .INIT(8'h00)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wr_data(wr_data),
    .wr_cs(wr_cs), .rd_cs(rd_cs), .rd_data(rd_data), .busy(busy)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // scoreboard compare
  task automatic check(input string name, input logic [dsz-1:0] got, input logic [dsz-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_readback(input string name);
    for (int a = 0; a < depth; a++) exp_q.push_back(8'h00);
    for (int a = 0; a < depth; a++) begin
      addr = asz'(a);
      #1;
      check(name, rd_data, exp_q.pop_front());
    end
  endtask

`ifdef ASYNC_MEM_CLEAR_EN
  // Drive a reset pulse, optionally re-asserting it restart_at cycles into the clear.
  task automatic run_clear(input int restart_at, input string name);
    reset = 1'b1; wr_cs = 1'b0; rd_cs = 1'b1; addr = '0;
    repeat (2) @(negedge clock);
    check({name, "_busy_in_reset"}, {7'b0, busy}, 8'h01);
    reset = 1'b0;
    if (restart_at >= 0) begin
      for (int i = 0; i < restart_at; i++) begin
        #1 check({name, "_busy_first"}, {7'b0, busy}, 8'h01);
        @(negedge clock);
      end
      reset = 1'b1;
      #1 check({name, "_busy_rereset"}, {7'b0, busy}, 8'h01);
      @(negedge clock);
      reset = 1'b0;
    end
    for (int i = 0; i < depth; i++) begin
      // Late in the clear, try to write a word that is already cleared.
      wr_cs   = (i >= 100);
      wr_data = 8'h99;
      addr    = (i >= 100) ? '0 : asz'(i);
      #1;
      check({name, "_busy_clear"}, {7'b0, busy}, 8'h01);
      check({name, "_rd_clear"}, rd_data, 8'hFF);
      @(negedge clock);
    end
    wr_cs = 1'b0;
    #1 check({name, "_busy_done"}, {7'b0, busy}, 8'h00);
    check_readback({name, "_init"});
  endtask
`endif

  typedef struct {
    logic           wr_cs;
    logic           rd_cs;
    logic [asz-1:0] addr;
    logic [dsz-1:0] wr_data;
    logic [dsz-1:0] exp_pre;
    logic [dsz-1:0] exp_post;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 7'h00, 8'hA5, 8'h00, 8'hA5};
    vecs[1]  = '{1'b1, 1'b1, 7'h7E, 8'h3C, 8'h00, 8'h3C};
    vecs[2]  = '{1'b1, 1'b1, 7'h7F, 8'h55, 8'hFF, 8'hFF};
    vecs[3]  = '{1'b0, 1'b1, 7'h00, 8'h00, 8'hA5, 8'hA5};
    vecs[4]  = '{1'b0, 1'b1, 7'h7E, 8'h00, 8'h3C, 8'h3C};
    vecs[5]  = '{1'b0, 1'b0, 7'h00, 8'h00, 8'hFF, 8'hFF};
    vecs[6]  = '{1'b0, 1'b1, 7'h00, 8'h11, 8'hA5, 8'hA5};
    vecs[7]  = '{1'b1, 1'b1, 7'h10, 8'h01, 8'h00, 8'h01};
    vecs[8]  = '{1'b1, 1'b1, 7'h10, 8'h02, 8'h01, 8'h02};
    vecs[9]  = '{1'b1, 1'b0, 7'h20, 8'h77, 8'hFF, 8'hFF};
    vecs[10] = '{1'b0, 1'b1, 7'h20, 8'h00, 8'h77, 8'h77};
    vecs[11] = '{1'b0, 1'b1, 7'h7F, 8'h00, 8'hFF, 8'hFF};

    reset = 1'b0; wr_cs = 1'b0; rd_cs = 1'b0; addr = '0; wr_data = '0;
    @(negedge clock);

`ifdef ASYNC_MEM_CLEAR_EN
    run_clear(-1, "clear");
`else
    // No sequencer: fill memory with zero so the table has a known start.
    rd_cs = 1'b1;
    for (int a = 0; a < depth; a++) begin
      wr_cs = 1'b1; addr = asz'(a); wr_data = 8'h00;
      #1 check("busy_tied_low", {7'b0, busy}, 8'h00);
      @(negedge clock);
    end
    wr_cs = 1'b0;
    check_readback("fill");
`endif

    for (int v = 0; v < 12; v++) begin
      wr_cs   = vecs[v].wr_cs;
      rd_cs   = vecs[v].rd_cs;
      addr    = vecs[v].addr;
      wr_data = vecs[v].wr_data;
      #1 check($sformatf("vec%0d_pre", v), rd_data, vecs[v].exp_pre);
      @(posedge clock);
      #1 check($sformatf("vec%0d_post", v), rd_data, vecs[v].exp_post);
      @(negedge clock);
    end
    wr_cs = 1'b0;

    // Out-of-range write must not alias onto the ends of the array.
    rd_cs = 1'b1;
    addr = 7'h00;
    #1 check("oor_keep_00", rd_data, 8'hA5);
    addr = 7'h7E;
    #1 check("oor_keep_7e", rd_data, 8'h3C);
    @(negedge clock);

`ifdef ASYNC_MEM_CLEAR_EN
    run_clear(50, "restart");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
